// File: rtl/rob_pkg.sv
// Reorder buffer shared types.
// Per-entry status flags and exception code constants.
package rob_pkg;

  localparam int EXCP_CODE_W = 6;

  localparam logic [EXCP_CODE_W-1:0] EXCP_ADEF = 6'h08;
  localparam logic [EXCP_CODE_W-1:0] EXCP_ALE  = 6'h09;
  localparam logic [EXCP_CODE_W-1:0] EXCP_ADEM = 6'h0a;

  typedef struct packed {
    logic                   valid;
    logic                   ready;
    logic                   is_store;
    logic                   serial;
    logic                   excp;
    logic                   mispred;
    logic [EXCP_CODE_W-1:0] excp_code;
  } rob_flags_t;

endpackage

// File: rtl/rob_commit_sel.sv
// Commit group selector.
// Walks the head window and returns the committing prefix.
module rob_commit_sel
  import rob_pkg::*;
#(
  parameter int CMT_W = 5
) (
  input  logic             stall,
  input  logic [CMT_W-1:0] rdy,
  input  logic [CMT_W-1:0] solo,
  input  logic [CMT_W-1:0] mispred,
  input  logic [CMT_W-1:0] is_store,
  output logic [CMT_W-1:0] cmt_valid
);

  logic stop;
  logic seen_st;

  // solo entries (exception/serial) may only lead a group
  always_comb begin
    cmt_valid = '0;
    stop      = stall;
    seen_st   = 1'b0;
    for (int k = 0; k < CMT_W; k++) begin
      if (!stop && rdy[k]
          && !(solo[k] && k != 0)
          && !(is_store[k] && seen_st)) begin
        cmt_valid[k] = 1'b1;
        stop         = solo[k] | mispred[k];
        seen_st      = seen_st | is_store[k];
      end else begin
        stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer.
// Occupancy-counted circular buffer with grouped in-order commit.
module rob_param
  import rob_pkg::*;
#(
  parameter  int DEPTH     = 64,
  parameter  int DISP_W    = 3,
  parameter  int CMT_W     = 5,
  parameter  int WB_N      = 6,
  parameter  int PAYLOAD_W = 49,
  localparam int TAG_W     = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [DISP_W-1:0]             disp_valid,
  input  logic [DISP_W*PAYLOAD_W-1:0]   disp_payload,
  input  logic [DISP_W-1:0]             disp_is_store,
  input  logic [DISP_W-1:0]             disp_serial,
  input  logic [DISP_W-1:0]             disp_has_excp,
  input  logic [DISP_W*EXCP_CODE_W-1:0] disp_excp_code,
  output logic                          disp_ready,
  output logic [DISP_W*TAG_W-1:0]       disp_tag,
  input  logic [WB_N-1:0]               wb_valid,
  input  logic [WB_N*TAG_W-1:0]         wb_tag,
  input  logic [WB_N-1:0]               wb_excp,
  input  logic [WB_N*EXCP_CODE_W-1:0]   wb_excp_code,
  input  logic [WB_N-1:0]               wb_mispred,
  input  logic                          cmt_stall,
  output logic [CMT_W-1:0]              cmt_valid,
  output logic [CMT_W*PAYLOAD_W-1:0]    cmt_payload,
  output logic                          cmt_excp,
  output logic [EXCP_CODE_W-1:0]        cmt_excp_code,
  output logic                          cmt_mispred,
  output logic [TAG_W-1:0]              head_tag,
  output logic [TAG_W:0]                count,
  output logic                          empty
);

  localparam int CNT_W = TAG_W + 1;
  localparam logic [TAG_W:0] DISP_LIM = CNT_W'(DEPTH - DISP_W);

  rob_flags_t           flags_q   [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [TAG_W-1:0]     head_q;
  logic [TAG_W-1:0]     tail_q;
  logic [TAG_W:0]       count_q;
  logic [TAG_W:0]       n_disp;
  logic [TAG_W:0]       n_cmt;

  rob_flags_t       win  [CMT_W];
  rob_flags_t       dent [DISP_W];
  logic [TAG_W-1:0] wt   [WB_N];
  logic [CMT_W-1:0] rdy_v;
  logic [CMT_W-1:0] solo_v;
  logic [CMT_W-1:0] misp_v;
  logic [CMT_W-1:0] st_v;

  // freed slots only become reusable once count_q reflects them
  assign disp_ready = count_q <= DISP_LIM;
  assign n_disp     = disp_ready ? CNT_W'($countones(disp_valid)) : '0;
  assign n_cmt      = CNT_W'($countones(cmt_valid));

  always_comb begin
    disp_tag = '0;
    for (int i = 0; i < DISP_W; i++) begin
      disp_tag[i*TAG_W +: TAG_W] = tail_q + TAG_W'(i);
      dent[i]           = '0;
      dent[i].valid     = 1'b1;
      dent[i].is_store  = disp_is_store[i];
      dent[i].serial    = disp_serial[i];
      dent[i].excp      = disp_has_excp[i];
      dent[i].excp_code = disp_has_excp[i]
        ? disp_excp_code[i*EXCP_CODE_W +: EXCP_CODE_W] : '0;
    end
  end

  always_comb begin
    for (int p = 0; p < WB_N; p++)
      wt[p] = wb_tag[p*TAG_W +: TAG_W];
  end

  always_comb begin
    rdy_v       = '0;
    solo_v      = '0;
    misp_v      = '0;
    st_v        = '0;
    cmt_payload = '0;
    for (int k = 0; k < CMT_W; k++) begin
      win[k]    = flags_q[head_q + TAG_W'(k)];
      rdy_v[k]  = win[k].valid & win[k].ready;
      solo_v[k] = win[k].excp | win[k].serial;
      misp_v[k] = win[k].mispred;
      st_v[k]   = win[k].is_store;
      cmt_payload[k*PAYLOAD_W +: PAYLOAD_W] =
        payload_q[head_q + TAG_W'(k)];
    end
  end

  rob_commit_sel #(.CMT_W(CMT_W)) u_sel (
    .stall     (cmt_stall),
    .rdy       (rdy_v),
    .solo      (solo_v),
    .mispred   (misp_v),
    .is_store  (st_v),
    .cmt_valid (cmt_valid)
  );

  assign cmt_excp      = cmt_valid[0] & win[0].excp;
  assign cmt_excp_code = cmt_excp ? win[0].excp_code : '0;
  assign cmt_mispred   = |(cmt_valid & misp_v);
  assign head_tag      = head_q;
  assign count         = count_q;
  assign empty         = count_q == '0;

  // wb first, then commit clear, so a committing entry ends fully clear
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        flags_q[i] <= '0;
    end else begin
      for (int p = WB_N - 1; p >= 0; p--) begin
        if (wb_valid[p] && flags_q[wt[p]].valid) begin
          flags_q[wt[p]].ready <= 1'b1;
          if (wb_mispred[p])
            flags_q[wt[p]].mispred <= 1'b1;
          if (wb_excp[p] && !flags_q[wt[p]].excp) begin
            flags_q[wt[p]].excp      <= 1'b1;
            flags_q[wt[p]].excp_code <=
              wb_excp_code[p*EXCP_CODE_W +: EXCP_CODE_W];
          end
        end
      end
      for (int k = 0; k < CMT_W; k++)
        if (cmt_valid[k])
          flags_q[head_q + TAG_W'(k)] <= '0;
      for (int i = 0; i < DISP_W; i++)
        if (disp_ready && disp_valid[i])
          flags_q[tail_q + TAG_W'(i)] <= dent[i];
      head_q  <= head_q + n_cmt[TAG_W-1:0];
      tail_q  <= tail_q + n_disp[TAG_W-1:0];
      count_q <= count_q + n_disp - n_cmt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DISP_W; i++)
      if (rst && !flush && disp_ready && disp_valid[i])
        payload_q[tail_q + TAG_W'(i)] <=
          disp_payload[i*PAYLOAD_W +: PAYLOAD_W];
  end

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer, successor to the fixed 64-entry, 3-in/5-out ROB in the commit unit.
- Depth, dispatch width, commit width and writeback port count are all parameters. Entry payload is opaque, so Rd/Pd/Pd_old packing is set by the instantiating core.
- Adds behaviour the fixed ROB lacks: an explicit occupancy counter, a downstream commit stall, and precise per-group stop rules (exception, mispredict, serialising op, one store per group).
- Sits between rename/dispatch and aRAT/free-list/LSU/CSR commit logic.

Parameters:
- DEPTH, 64, number of entries; power of two, 8..256.
- DISP_W, 3, dispatch slots per cycle.
- CMT_W, 5, commit slots per cycle; CMT_W <= DEPTH.
- WB_N, 6, writeback (completion) ports.
- PAYLOAD_W, 49, opaque per-entry payload bits (pc, Rd, Pd, Pd_old, RegWr, ...).
- TAG_W, $clog2(DEPTH), tag width; derived, never overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- flush  in  1  pipeline flush; empties ROB
- disp_valid  in  DISP_W  slot valids; must be a contiguous prefix from slot 0
- disp_payload  in  DISP_W x PAYLOAD_W  per-slot payload
- disp_is_store / disp_serial / disp_has_excp  in  DISP_W each  per-slot flags
- disp_excp_code  in  DISP_W x 6  front-end exception code
- disp_ready  out  1  dispatch accepted this cycle (all-or-none)
- disp_tag  out  DISP_W x TAG_W  tag of slot i = tail + i
- wb_valid  in  WB_N  completion strobes
- wb_tag  in  WB_N x TAG_W  completing entry
- wb_excp  in  WB_N  late exception (e.g. LSU)
- wb_excp_code  in  WB_N x 6  late exception code
- wb_mispred  in  WB_N  branch resolved mispredicted
- cmt_stall  in  1  downstream cannot accept commits
- cmt_valid  out  CMT_W  contiguous prefix of committing slots
- cmt_payload  out  CMT_W x PAYLOAD_W  payload of head + i
- cmt_excp  out  1  slot 0 commits with exception
- cmt_excp_code  out  6  valid when cmt_excp
- cmt_mispred  out  1  last committing slot is a mispredicted branch
- head_tag  out  TAG_W  oldest entry
- count  out  TAG_W+1  occupancy
- empty  out  1  count == 0

Behaviour:
- Reset (rst == 0 at a clk edge) and flush are identical, and flush beats every other event in the same cycle.
  - head = tail = count = 0; all valid/ready/excp/mispred bits cleared.
  - Outputs after reset: cmt_valid = 0, cmt_excp = 0, cmt_mispred = 0, count = 0, empty = 1, disp_ready = 1.
- Dispatch:
  - disp_ready = (count <= DEPTH - DISP_W), evaluated on the registered count; slots freed by this cycle's commit are not reusable until the next cycle.
  - When disp_ready is high, each valid slot i writes entry tail + i (mod DEPTH) with valid = 1, ready = 0 and its flags.
  - tail advances by popcount(disp_valid).
  - When disp_ready is low, nothing is written.
- Writeback:
  - Each port sets ready on entry wb_tag; it sets excp and code only if the entry does not already hold an exception; it sets mispred.
  - Writeback to an entry with valid = 0 is ignored.
  - On duplicate tags in one cycle, the lowest port index wins the code.
  - Writeback becomes visible to commit on the next cycle (1-cycle latency).
- Commit, combinational from registered state. Slot k commits iff all of the following hold:
  - cmt_stall == 0;
  - slots 0..k-1 commit;
  - entry head + k has valid && ready;
  - stop rules are respected:
    - An entry with excp or serial commits only at slot 0 and ends the group.
    - A mispredicted entry commits and ends the group (inclusive).
    - A second store in the group does not commit.
- Commit state update:
  - cmt_excp = slot 0 commits && entry excp.
  - Committed entries are cleared and head advances by popcount(cmt_valid), with wrap mod DEPTH.
  - count_next = count + dispatched - committed; dispatch and commit happen in the same cycle.
- Wrap: tags and pointers are TAG_W bits and wrap naturally. Full versus empty is resolved by count, never by pointer compare.

Decomposition:
- Shared package rob_pkg holds:
  - the rob_flags_t struct (valid, ready, is_store, serial, excp, mispred, excp_code);
  - the EXCP_CODE_W = 6 constant;
  - the ALE/ADEM/ADEF code constants.
- Sub-module rob_commit_sel: purely combinational CMT_W-wide stop-rule prefix selector. It takes per-slot flag vectors and returns cmt_valid.

Test Plan:
- Reset then dispatch 3 valid slots for 21 cycles with no writeback → count = 63, disp_ready = 0 at count 62+; tags 0..62 issued in order, wrap untested yet.
- Dispatch 5 entries, writeback tags 0,1,2,4 → next cycle cmt_valid = 00111, head_tag = 3; after writeback of tag 3, cmt_valid = 00011 (tags 3,4).
- Entries 0..4 all ready, entry 2 wb_excp code ALE → cycle 1 cmt_valid = 00011; cycle 2 cmt_valid = 00001 with cmt_excp = 1, code = ALE.
- Entries 0..4 ready, entry 1 mispred, entries 2 and 3 both stores → commits {0,1} with cmt_mispred = 1, then {2}, then {3,4}.
- Fill to count 60, commit 5 while dispatching 3 across the DEPTH boundary → tags wrap 63 → 0, count = 58, no entry overwritten.
- Assert flush (or rst = 0) while a commit and a dispatch are pending → next cycle count = 0, empty = 1, cmt_valid = 0, and a stale writeback to old tag 7 leaves entry 7 invalid.
